// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: FSM encoding and
// default master configuration values.
package i2c_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_XFER = 2'd2,
      ST_FIN  = 2'd3
   } txn_state_e;

   localparam logic [1:0]  MODE_DEF = 2'b10;
   localparam logic [10:0] DIV_DEF  = 11'd499;
   localparam logic [19:0] TOUT_DEF = 20'd2000;
endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide round-robin arbiter: one-hot grant searching from the pointer,
// pointer moves past the last owner when upd_i is pulsed.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            upd_i,
   input  logic [IW-1:0]   upd_idx_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   gnt_idx_o
);
   logic [IW-1:0] ptr_q;
   logic          found;

   function automatic int wrap(input int v);
      return (v >= NREQ) ? v - NREQ : v;
   endfunction

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_i[wrap(int'(ptr_q) + i)]) begin
            found                          = 1'b1;
            gnt_o[wrap(int'(ptr_q) + i)]   = 1'b1;
            gnt_idx_o                      = IW'(wrap(int'(ptr_q) + i));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (upd_i) begin
         ptr_q <= (upd_idx_i == IW'(NREQ - 1)) ? '0 : upd_idx_i + 1'b1;
      end
   end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between NREQ requesters: round-robin grant, one-byte
// write stage, read byte fan-out and per-owner completion signalling.
//
// state   | meaning
// IDLE    | waiting for a request; grant and latch addr_rw/cnt
// LOAD    | master configuration driven, first write byte prefetched
// XFER    | i2c_ready high; bytes moved on master strobes
// FIN     | i2c_ready low; done/err issued, round-robin pointer advanced
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int          NREQ     = 2,
   parameter logic [1:0]  MODE_DEF = i2c_pkg::MODE_DEF,
   parameter logic [10:0] DIV_DEF  = i2c_pkg::DIV_DEF,
   parameter logic [19:0] TOUT_DEF = i2c_pkg::TOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_addr_rw,
   input  logic [8*NREQ-1:0] req_cnt,
   output logic [NREQ-1:0]   req_grant,
   input  logic [8*NREQ-1:0] wr_data,
   input  logic [NREQ-1:0]   wr_valid,
   output logic [NREQ-1:0]   wr_ready,
   output logic [7:0]        rd_data,
   output logic [NREQ-1:0]   rd_valid,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic              busy,
   output logic              i2c_ready,
   output logic [1:0]        mode_i2c,
   output logic [10:0]       div_cnt,
   output logic [19:0]       time_out,
   output logic [7:0]        data_addr_rw,
   output logic [7:0]        data_cnt,
   output logic [7:0]        data_in,
   input  logic [7:0]        data_out,
   input  logic              m_byte_req,
   input  logic              m_byte_vld,
   input  logic              m_done,
   input  logic              m_err
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   txn_state_e      state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [7:0]      addr_rw_q, addr_rw_d, cnt_q, cnt_d;
   logic [7:0]      rem_q, rem_d, fetch_q, fetch_d;
   logic [7:0]      stage_q, stage_d, data_in_q, data_in_d, rd_data_q, rd_data_d;
   logic            stage_full_q, stage_full_d, ready_q, ready_d;
   logic            errp_q, errp_d, err_q, err_d;
   logic [NREQ-1:0] grant_q, grant_d, rd_valid_q, rd_valid_d, done_q, done_d;
   logic [NREQ-1:0] gnt_oh, own_oh;
   logic [IW-1:0]   gnt_idx;
   logic [7:0]      sel_cnt, own_wr_data;
   logic            is_wr, wr_take, rr_upd;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk       (clk),
      .rst_n     (rst),
      .req_i     (req_valid),
      .upd_i     (rr_upd),
      .upd_idx_i (owner_q),
      .gnt_o     (gnt_oh),
      .gnt_idx_o (gnt_idx)
   );

   assign own_oh      = NREQ'(1) << owner_q;
   assign own_wr_data = wr_data[owner_q*8 +: 8];
   assign sel_cnt     = req_cnt[gnt_idx*8 +: 8];
   assign is_wr       = !addr_rw_q[0];

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      addr_rw_d    = addr_rw_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      fetch_d      = fetch_q;
      stage_d      = stage_q;
      stage_full_d = stage_full_q;
      data_in_d    = data_in_q;
      rd_data_d    = rd_data_q;
      ready_d      = ready_q;
      errp_d       = errp_q;
      err_d        = 1'b0;
      grant_d      = '0;
      rd_valid_d   = '0;
      done_d       = '0;
      rr_upd       = 1'b0;
      wr_take      = 1'b0;

      // Stage refills whenever empty; never fetches more than cnt bytes.
      if ((state_q == ST_LOAD || state_q == ST_XFER) && is_wr && !stage_full_q &&
          fetch_q != '0 && wr_valid[owner_q]) begin
         wr_take      = 1'b1;
         stage_d      = own_wr_data;
         stage_full_d = 1'b1;
         fetch_d      = fetch_q - 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               owner_d      = gnt_idx;
               grant_d      = gnt_oh;
               addr_rw_d    = req_addr_rw[gnt_idx*8 +: 8];
               cnt_d        = sel_cnt;
               rem_d        = sel_cnt;
               fetch_d      = sel_cnt;
               stage_full_d = 1'b0;
               errp_d       = (sel_cnt == '0);
               state_d      = (sel_cnt == '0) ? ST_FIN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            ready_d = 1'b1;
            state_d = ST_XFER;
         end
         ST_XFER: begin
            // m_done wins over any byte strobe in the same cycle.
            if (m_done) begin
               errp_d  = m_err || (rem_q != '0);
               ready_d = 1'b0;
               state_d = ST_FIN;
            end else if (is_wr && m_byte_req && rem_q != '0) begin
               if (stage_full_q) begin
                  data_in_d    = stage_q;
                  stage_full_d = 1'b0;
                  rem_d        = rem_q - 8'd1;
               end else begin
                  errp_d  = 1'b1;
                  ready_d = 1'b0;
                  state_d = ST_FIN;
               end
            end else if (!is_wr && m_byte_vld && rem_q != '0) begin
               rd_data_d  = data_out;
               rd_valid_d = own_oh;
               rem_d      = rem_q - 8'd1;
            end
         end
         ST_FIN: begin
            done_d       = own_oh;
            err_d        = errp_q;
            rr_upd       = 1'b1;
            ready_d      = 1'b0;
            stage_full_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         addr_rw_q    <= '0;
         cnt_q        <= '0;
         rem_q        <= '0;
         fetch_q      <= '0;
         stage_q      <= '0;
         stage_full_q <= 1'b0;
         data_in_q    <= '0;
         rd_data_q    <= '0;
         ready_q      <= 1'b0;
         errp_q       <= 1'b0;
         err_q        <= 1'b0;
         grant_q      <= '0;
         rd_valid_q   <= '0;
         done_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         addr_rw_q    <= addr_rw_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
         fetch_q      <= fetch_d;
         stage_q      <= stage_d;
         stage_full_q <= stage_full_d;
         data_in_q    <= data_in_d;
         rd_data_q    <= rd_data_d;
         ready_q      <= ready_d;
         errp_q       <= errp_d;
         err_q        <= err_d;
         grant_q      <= grant_d;
         rd_valid_q   <= rd_valid_d;
         done_q       <= done_d;
      end
   end

   assign req_grant    = grant_q;
   assign wr_ready     = wr_take ? own_oh : '0;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign done         = done_q;
   assign err          = err_q;
   assign busy         = (state_q != ST_IDLE);
   assign i2c_ready    = ready_q;
   assign mode_i2c     = MODE_DEF;
   assign div_cnt      = DIV_DEF;
   assign time_out     = TOUT_DEF;
   assign data_addr_rw = addr_rw_q;
   assign data_cnt     = cnt_q;
   assign data_in      = data_in_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: two requesters, a writer model for
// requester 0 and a scripted I2C master.
module tb_i2c_txn_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_grant, wr_valid, wr_ready, rd_valid, done;
   logic [15:0] req_addr_rw, req_cnt, wr_data;
   logic [7:0]  rd_data, data_addr_rw, data_cnt, data_in, data_out;
   logic        err, busy, i2c_ready, m_byte_req, m_byte_vld, m_done, m_err;
   logic [1:0]  mode_i2c;
   logic [10:0] div_cnt;
   logic [19:0] time_out;

   int n_chk = 0, n_err = 0;
   int gnt_seen = 0;
   logic ready_seen = 1'b0;
   logic [31:0] exp_gnt[$], exp_rd[$], exp_done[$], exp_din[$];
   logic [31:0] e;

   logic [7:0] wr_bytes[0:3];
   int  wr_ptr = 0, wr_off = 0, wr_n = 0;
   logic wr_en = 1'b0;

   i2c_txn_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr_rw(req_addr_rw), .req_cnt(req_cnt),
      .req_grant(req_grant),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .err(err), .busy(busy),
      .i2c_ready(i2c_ready), .mode_i2c(mode_i2c), .div_cnt(div_cnt),
      .time_out(time_out), .data_addr_rw(data_addr_rw), .data_cnt(data_cnt),
      .data_in(data_in), .data_out(data_out),
      .m_byte_req(m_byte_req), .m_byte_vld(m_byte_vld),
      .m_done(m_done), .m_err(m_err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Requester 0 writer: offers the next queued byte, advances on wr_ready.
   always @(posedge clk) if (wr_valid[0] && wr_ready[0]) wr_ptr <= wr_ptr + 1;
   always @(negedge clk) begin
      int k;
      k = wr_ptr - wr_off;
      if (wr_en && k < wr_n && k < 4) begin
         wr_valid = 2'b01;
         wr_data  = {8'h00, wr_bytes[k]};
      end else begin
         wr_valid = 2'b00;
      end
   end

   // Output monitor: every pulse must match the head of its expectation queue.
   always @(negedge clk) begin
      if (rst) begin
         if (i2c_ready) ready_seen = 1'b1;
         if (req_grant != 2'b00) begin
            gnt_seen++;
            if (exp_gnt.size() == 0) chk_eq("unexp_grant", 32'(req_grant), 0);
            else begin e = exp_gnt.pop_front(); chk_eq("grant", 32'(req_grant), e); end
         end
         if (rd_valid != 2'b00) begin
            if (exp_rd.size() == 0) chk_eq("unexp_rd", {rd_valid, rd_data}, 0);
            else begin e = exp_rd.pop_front(); chk_eq("rd_byte", {rd_valid, rd_data}, e); end
         end
         if (done != 2'b00) begin
            if (exp_done.size() == 0) chk_eq("unexp_done", {done, err}, 0);
            else begin e = exp_done.pop_front(); chk_eq("done_err", {done, err}, e); end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!i2c_ready && t < 50) begin @(negedge clk); t++; end
      chk_eq("ready_up", 32'(i2c_ready), 1);
   endtask

   task automatic master_wr_byte();
      logic [31:0] x;
      @(negedge clk); m_byte_req = 1'b1;
      @(negedge clk); m_byte_req = 1'b0;
      x = (exp_din.size() != 0) ? exp_din.pop_front() : 32'hdead;
      chk_eq("data_in", 32'(data_in), x);
      tick(2);
   endtask

   task automatic queues_empty(input string tag);
      chk_eq({tag, "_gnt_left"}, exp_gnt.size(), 0);
      chk_eq({tag, "_rd_left"}, exp_rd.size(), 0);
      chk_eq({tag, "_done_left"}, exp_done.size(), 0);
   endtask

   initial begin
      rst = 1'b0;
      req_valid = '0; req_addr_rw = '0; req_cnt = '0;
      wr_valid = '0; wr_data = '0; data_out = '0;
      m_byte_req = 0; m_byte_vld = 0; m_done = 0; m_err = 0;
      #1;
      chk_eq("rst_outs", {req_grant, wr_ready, rd_valid, done, err, busy, i2c_ready}, 0);
      chk_eq("rst_mode", 32'(mode_i2c), 2'b10);
      chk_eq("rst_div", 32'(div_cnt), 499);
      chk_eq("rst_tout", 32'(time_out), 2000);
      chk_eq("rst_data", {data_in, data_addr_rw, data_cnt, rd_data}, 0);
      tick(3);
      rst = 1'b1;
      tick(2);

      // Write: req0, 4 bytes; final step is a surplus byte_req together with m_done.
      wr_bytes[0] = 8'h00; wr_bytes[1] = 8'h08; wr_bytes[2] = 8'h01; wr_bytes[3] = 8'h02;
      wr_off = wr_ptr; wr_n = 4;
      foreach (wr_bytes[i]) exp_din.push_back(32'(wr_bytes[i]));
      @(negedge clk);
      req_addr_rw = 16'h0020; req_cnt = 16'h0004; req_valid = 2'b01; wr_en = 1'b1;
      exp_gnt.push_back(32'b01);
      @(negedge clk); req_valid = 2'b00;
      wait_ready();
      for (int i = 0; i < 4; i++) master_wr_byte();
      @(negedge clk); m_byte_req = 1'b1; m_done = 1'b1; exp_done.push_back(3'b010);
      @(negedge clk); m_byte_req = 1'b0; m_done = 1'b0;
      chk_eq("din_hold", 32'(data_in), 8'h02);
      tick(4);
      wr_en = 1'b0;
      queues_empty("wr");

      // Read: req1, cnt=3, master offers a fourth surplus byte.
      @(negedge clk);
      req_addr_rw = 16'h2100; req_cnt = 16'h0300; req_valid = 2'b10;
      exp_gnt.push_back(32'b10);
      @(negedge clk); req_valid = 2'b00;
      wait_ready();
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         b = 8'hAA + 8'(i * 17);
         @(negedge clk); data_out = b; m_byte_vld = 1'b1;
         if (i < 3) exp_rd.push_back({22'd0, 2'b10, b});
         @(negedge clk); m_byte_vld = 1'b0;
         tick(1);
      end
      @(negedge clk); m_done = 1'b1; exp_done.push_back(3'b100);
      @(negedge clk); m_done = 1'b0;
      tick(4);
      queues_empty("rd");

      // Both requesting continuously with cnt=0: grants alternate 0,1,0,1.
      ready_seen = 1'b0; gnt_seen = 0;
      req_addr_rw = 16'h2020; req_cnt = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         exp_gnt.push_back((i % 2 == 0) ? 32'b01 : 32'b10);
         exp_done.push_back((i % 2 == 0) ? 32'b011 : 32'b101);
      end
      @(negedge clk); req_valid = 2'b11;
      for (int t = 0; t < 40 && gnt_seen < 4; t++) @(negedge clk);
      req_valid = 2'b00;
      chk_eq("rr_grants", gnt_seen, 4);
      tick(4);
      chk_eq("rr_no_ready", 32'(ready_seen), 0);
      queues_empty("rr");

      // Write cnt=2 with only one byte supplied: second byte_req aborts.
      wr_bytes[0] = 8'h5A; wr_off = wr_ptr; wr_n = 1; exp_din.push_back(32'h5A);
      @(negedge clk);
      req_addr_rw = 16'h0020; req_cnt = 16'h0002; req_valid = 2'b01; wr_en = 1'b1;
      exp_gnt.push_back(32'b01);
      @(negedge clk); req_valid = 2'b00;
      wait_ready();
      master_wr_byte();
      @(negedge clk); m_byte_req = 1'b1; exp_done.push_back(3'b011);
      @(negedge clk); m_byte_req = 1'b0;
      chk_eq("abort_ready_low", 32'(i2c_ready), 0);
      tick(4);
      wr_en = 1'b0;
      queues_empty("abort");

      // cnt=0 on req0: done+err the cycle after the grant, master never readied.
      ready_seen = 1'b0;
      req_cnt = 16'h0000;
      exp_gnt.push_back(32'b01); exp_done.push_back(3'b011);
      @(negedge clk); req_valid = 2'b01;
      @(negedge clk); req_valid = 2'b00;
      chk_eq("zero_grant", 32'(req_grant), 2'b01);
      @(negedge clk);
      chk_eq("zero_done_next", {done, err}, 3'b011);
      tick(3);
      chk_eq("zero_no_ready", 32'(ready_seen), 0);
      queues_empty("zero");

      // Reset during a req1 read; afterwards req0 must win.
      @(negedge clk);
      req_addr_rw = 16'h2100; req_cnt = 16'h0200; req_valid = 2'b10;
      exp_gnt.push_back(32'b10);
      @(negedge clk); req_valid = 2'b00;
      wait_ready();
      @(negedge clk); #2 rst = 1'b0;
      #1;
      chk_eq("arst_ready", 32'(i2c_ready), 0);
      chk_eq("arst_outs", {req_grant, rd_valid, done, err, busy}, 0);
      chk_eq("arst_mode", 32'(mode_i2c), 2'b10);
      tick(2);
      rst = 1'b1;
      tick(3);
      req_addr_rw = 16'h2020; req_cnt = 16'h0000;
      exp_gnt.push_back(32'b01); exp_done.push_back(3'b011);
      @(negedge clk); req_valid = 2'b11;
      @(negedge clk); req_valid = 2'b00;
      tick(4);
      queues_empty("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end
endmodule
